// File: rtl/ext_pipe_pkg.sv
// Shared extend-mode encodings for the immediate extension pipeline.
// Every user of an ext_op code takes it from here rather than a local literal.
package ext_pipe_pkg;

    localparam int EXT_OP_LENGTH = 3;

    localparam logic [EXT_OP_LENGTH-1:0] EXT_OP_DEFAULT     = 3'b000;
    localparam logic [EXT_OP_LENGTH-1:0] EXT_OP_SFT         = 3'b001;
    localparam logic [EXT_OP_LENGTH-1:0] EXT_OP_SIGNED      = 3'b010;
    localparam logic [EXT_OP_LENGTH-1:0] EXT_OP_UNSIGNED    = 3'b011;
    localparam logic [EXT_OP_LENGTH-1:0] EXT_OP_SIGNED_SHL2 = 3'b100;
    localparam logic [EXT_OP_LENGTH-1:0] EXT_OP_SBYTE       = 3'b101;
    localparam logic [EXT_OP_LENGTH-1:0] EXT_OP_UBYTE       = 3'b110;
    localparam logic [EXT_OP_LENGTH-1:0] EXT_OP_RESERVED    = 3'b111;

endpackage

// File: rtl/ext_core.sv
// Combinational extend-mode decode: turns an immediate and an ext_op into
// the widened result, flagging reserved modes.
module ext_core
    import ext_pipe_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 32,
    parameter int OP_W   = EXT_OP_LENGTH
) (
    input  logic [DATA_W-1:0] imm,
    input  logic [OP_W-1:0]   ext_op,
    output logic [OUT_W-1:0]  ext_out,
    output logic              err
);

    logic [OUT_W-1:0]    zext;
    logic [OUT_W-1:0]    sext;
    logic [2*DATA_W-1:0] sft_full;

    assign zext     = OUT_W'(imm);
    assign sext     = OUT_W'($signed(imm));
    assign sft_full = {imm, {DATA_W{1'b0}}};

    // Reserved or unknown modes fall back to zero-extension with err raised.
    always_comb begin
        ext_out = zext;
        err     = 1'b0;
        case (ext_op)
            OP_W'(EXT_OP_DEFAULT),
            OP_W'(EXT_OP_UNSIGNED):    ext_out = zext;
            OP_W'(EXT_OP_SFT):         ext_out = OUT_W'(sft_full);
            OP_W'(EXT_OP_SIGNED):      ext_out = sext;
            OP_W'(EXT_OP_SIGNED_SHL2): ext_out = sext << 2;
            OP_W'(EXT_OP_SBYTE):       ext_out = OUT_W'($signed(imm[7:0]));
            OP_W'(EXT_OP_UBYTE):       ext_out = OUT_W'(imm[7:0]);
            default: begin
                ext_out = zext;
                err     = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ext_pipe.sv
// Immediate extension stage with a valid/ready handshake: one output register
// plus one skid register, one cycle of latency, synchronous flush.
module ext_pipe
    import ext_pipe_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 32,
    parameter int OP_W   = EXT_OP_LENGTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] imm,
    input  logic [OP_W-1:0]   ext_op,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  ext_out,
    output logic              out_err
);

    logic [OUT_W-1:0] core_out;
    logic             core_err;
    logic [OUT_W-1:0] skid_data;
    logic             skid_err;
    logic             skid_valid;
    logic             take_in;
    logic             take_out;
    logic             out_free;

    ext_core #(
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W),
        .OP_W   (OP_W)
    ) u_core (
        .imm     (imm),
        .ext_op  (ext_op),
        .ext_out (core_out),
        .err     (core_err)
    );

    assign in_ready = !skid_valid;
    assign take_in  = in_valid && in_ready;
    assign take_out = out_valid && out_ready;
    assign out_free = !out_valid || take_out;

    // When skid_valid is set in_ready is low, so a skid refill and a fresh
    // input can never compete for the output register on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            ext_out    <= '0;
            out_err    <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_err   <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                ext_out    <= skid_data;
                out_err    <= skid_err;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (take_in) begin
                ext_out   <= core_out;
                out_err   <= core_err;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (take_in) begin
            skid_data  <= core_out;
            skid_err   <= core_err;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe: directed vector table, handshake corner
// sequences, and a randomized run against a queue-based reference model.
module tb_ext_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] imm;
    logic [2:0]  ext_op;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ext_out;
    logic        out_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] imm;
        logic [2:0]  op;
        logic [31:0] exp_out;
        logic        exp_err;
    } vec_t;

    vec_t vecs[14];

    ext_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm       (imm),
        .ext_op    (ext_op),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ext_out   (ext_out),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    // Reference: extension computed with integer arithmetic, {err, data}.
    function automatic logic [32:0] refExt(input logic [15:0] v, input logic [2:0] op);
        int sv;
        int sb;
        logic [31:0] r;
        logic e;
        sv = v[15] ? int'(v) - 65536 : int'(v);
        sb = v[7] ? int'(v[7:0]) - 256 : int'(v[7:0]);
        e  = 1'b0;
        case (op)
            3'd0, 3'd3: r = 32'(int'(v));
            3'd1:       r = 32'(int'(v) * 65536);
            3'd2:       r = 32'(sv);
            3'd4:       r = 32'(sv * 4);
            3'd5:       r = 32'(sb);
            3'd6:       r = 32'(int'(v[7:0]));
            default: begin
                r = 32'(int'(v));
                e = 1'b1;
            end
        endcase
        return {e, r};
    endfunction

    task automatic applyStimulus(input logic v, input logic [15:0] i, input logic [2:0] op,
                                 input logic rdy, input logic fl);
        in_valid  = v;
        imm       = i;
        ext_op    = op;
        out_ready = rdy;
        flush     = fl;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkResult(input string name, input logic [31:0] data, input logic err);
        checkOutput({name, " valid"}, 32'(out_valid), 32'd1);
        checkOutput({name, " data"}, ext_out, data);
        checkOutput({name, " err"}, 32'(out_err), 32'(err));
    endtask

    logic [32:0] q[$];
    logic [32:0] r;

    initial begin
        vecs[0]  = '{16'h8001, 3'b010, 32'hFFFF8001, 1'b0};
        vecs[1]  = '{16'h1234, 3'b001, 32'h12340000, 1'b0};
        vecs[2]  = '{16'hFFFF, 3'b100, 32'hFFFFFFFC, 1'b0};
        vecs[3]  = '{16'h00F0, 3'b101, 32'hFFFFFFF0, 1'b0};
        vecs[4]  = '{16'h00F0, 3'b110, 32'h000000F0, 1'b0};
        vecs[5]  = '{16'h00F0, 3'b111, 32'h000000F0, 1'b1};
        vecs[6]  = '{16'h8001, 3'b000, 32'h00008001, 1'b0};
        vecs[7]  = '{16'h8001, 3'b011, 32'h00008001, 1'b0};
        vecs[8]  = '{16'h7FFF, 3'b010, 32'h00007FFF, 1'b0};
        vecs[9]  = '{16'h2000, 3'b100, 32'h00008000, 1'b0};
        vecs[10] = '{16'hC000, 3'b100, 32'hFFFF0000, 1'b0};
        vecs[11] = '{16'hAB7F, 3'b101, 32'h0000007F, 1'b0};
        vecs[12] = '{16'hAB80, 3'b110, 32'h00000080, 1'b0};
        vecs[13] = '{16'hFFFF, 3'b001, 32'hFFFF0000, 1'b0};

        rst_n = 1'b0;
        applyStimulus(1'b0, 16'h0, 3'd0, 1'b1, 1'b0);
        #2;
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset ext_out", ext_out, 32'd0);
        checkOutput("reset out_err", 32'(out_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back table vectors at full throughput.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i > 0) checkResult($sformatf("vec%0d", i - 1), vecs[i-1].exp_out, vecs[i-1].exp_err);
            checkOutput($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
            applyStimulus(1'b1, vecs[i].imm, vecs[i].op, 1'b1, 1'b0);
        end
        @(negedge clk);
        checkResult("vec13", vecs[13].exp_out, vecs[13].exp_err);
        applyStimulus(1'b0, 16'h0, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("drain out_valid", 32'(out_valid), 32'd0);

        // Stall: A to output, B to skid, C held off until the skid drains.
        applyStimulus(1'b1, 16'h1111, 3'b011, 1'b0, 1'b0);
        @(negedge clk);
        checkResult("stall A", 32'h00001111, 1'b0);
        checkOutput("stall in_ready A", 32'(in_ready), 32'd1);
        applyStimulus(1'b1, 16'h8222, 3'b010, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("stall in_ready B", 32'(in_ready), 32'd0);
        checkResult("stall hold A", 32'h00001111, 1'b0);
        applyStimulus(1'b1, 16'h0033, 3'b110, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("stall in_ready C", 32'(in_ready), 32'd0);
        checkResult("stall hold A2", 32'h00001111, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        checkResult("stall B", 32'hFFFF8222, 1'b0);
        checkOutput("stall in_ready back", 32'(in_ready), 32'd1);
        @(negedge clk);
        checkResult("stall C", 32'h00000033, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("stall empty", 32'(out_valid), 32'd0);

        // Flush with two held items and an offered input.
        applyStimulus(1'b1, 16'h0101, 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 16'h0202, 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("flush pre in_ready", 32'(in_ready), 32'd0);
        applyStimulus(1'b1, 16'h0303, 3'b000, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("flush out_valid", 32'(out_valid), 32'd0);
        checkOutput("flush in_ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b0, 16'h0, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("flush no ghost", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 16'h0, 3'd0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("empty flush out_valid", 32'(out_valid), 32'd0);
        checkOutput("empty flush in_ready", 32'(in_ready), 32'd1);

        // Asynchronous reset mid-stream, then first input after release.
        applyStimulus(1'b1, 16'h0A0A, 3'b011, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 16'h0B0B, 3'b011, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("pre-reset out_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("async reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("async reset ext_out", ext_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 16'h0E0E, 3'b010, 1'b1, 1'b0);
        @(negedge clk);
        checkResult("post-reset first", 32'h00000E0E, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("post-reset empty", 32'(out_valid), 32'd0);

        // Randomized traffic against a two-entry FIFO model.
        q.delete();
        for (int c = 0; c < 400; c++) begin
            logic v, rdy, fl, acc, drn;
            logic [15:0] ri;
            logic [2:0]  ro;
            checkOutput("rnd out_valid", 32'(out_valid), 32'(q.size() > 0));
            checkOutput("rnd in_ready", 32'(in_ready), 32'(q.size() < 2));
            if (q.size() > 0) begin
                checkOutput("rnd data", ext_out, q[0][31:0]);
                checkOutput("rnd err", 32'(out_err), 32'(q[0][32]));
            end
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 15) == 0);
            ri  = 16'($urandom);
            ro  = 3'($urandom_range(0, 7));
            applyStimulus(v, ri, ro, rdy, fl);
            acc = v && (q.size() < 2);
            drn = rdy && (q.size() > 0);
            if (fl) begin
                q.delete();
            end else begin
                if (drn) void'(q.pop_front());
                if (acc) begin
                    r = refExt(ri, ro);
                    q.push_back(r);
                end
            end
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
